// File: rtl/cargo_pkg.sv
// Shared types and helpers for the cargo diverter path.
// Latency: none (declarations and a pure function only).
// Backpressure: n/a.
package cargo_pkg;

  // Gate position codes driven onto the diverter actuator
  localparam logic [1:0] GATE_NEUTRAL = 2'b00;
  localparam logic [1:0] GATE_LIGHT   = 2'b01;
  localparam logic [1:0] GATE_MEDIUM  = 2'b10;
  localparam logic [1:0] GATE_HEAVY   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    PUSH   = 2'd2,
    CLOSE  = 2'd3
  } divert_state_t;

  // Gate code plus a flag saying whether the class was exactly one-hot
  typedef struct packed {
    logic       vld;
    logic [1:0] code;
  } gate_sel_t;

  // cls is {heavy, medium, light}; anything not exactly one-hot is invalid
  function automatic gate_sel_t class_to_gate(input logic [2:0] cls);
    gate_sel_t r;
    r.vld  = 1'b1;
    r.code = GATE_NEUTRAL;
    case (cls)
      3'b001:  r.code = GATE_LIGHT;
      3'b010:  r.code = GATE_MEDIUM;
      3'b100:  r.code = GATE_HEAVY;
      default: r.vld  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cargo_bin_counter.sv
// Saturating per-class item counter with synchronous clear.
// Latency: count visible the cycle after inc; clear wins over inc on the same edge.
// Backpressure: none; holds at all-ones instead of wrapping.
module cargo_bin_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Clear has priority; increment stops at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cargo_diverter.sv
// Three-way diverter gate sequencer: accept one classified item, settle gate, push, close.
// Latency: gate from cycle 1 after handshake, push for PUSH_CYCLES, ready again after S+P+2 cycles.
// Backpressure: in_ready low from accept until the cycle after CLOSE; in_valid may be held.
module cargo_diverter
  import cargo_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PUSH_CYCLES   = 8,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             light,
  input  logic             medium_,
  input  logic             heavy,
  input  logic             clear_cnt,
  output logic [1:0]       gate,
  output logic             push,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] light_cnt,
  output logic [CNT_W-1:0] medium_cnt,
  output logic [CNT_W-1:0] heavy_cnt
);

  // The timer only ever holds a load value minus one, counting down to zero
  localparam int TMR_MAX = (SETTLE_CYCLES > PUSH_CYCLES) ? SETTLE_CYCLES : PUSH_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] PUSH_LOAD   = TMR_W'(PUSH_CYCLES - 1);

  divert_state_t    state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  gate_sel_t        sel;
  logic             hs;
  logic [1:0]       gate_d;
  logic             push_d;
  logic             ready_d;
  logic             err_d;
  logic             push_entry;

  assign sel = class_to_gate({heavy, medium_, light});
  assign hs  = in_valid && in_ready;

  // State and timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next state: accept only one-hot classes, then walk settle/push/close
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (hs && sel.vld) begin
          state_d = SETTLE;
          timer_d = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (timer_q == '0) begin
          state_d = PUSH;
          timer_d = PUSH_LOAD;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      PUSH: begin
        if (timer_q == '0) begin
          state_d = CLOSE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      CLOSE: begin
        state_d = IDLE;
        timer_d = '0;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    gate_d  = GATE_NEUTRAL;
    push_d  = 1'b0;
    ready_d = 1'b0;
    err_d   = (state_q == IDLE) && hs && !sel.vld;
    case (state_d)
      IDLE:    ready_d = 1'b1;
      SETTLE:  gate_d  = (state_q == IDLE) ? sel.code : gate;
      PUSH: begin
        gate_d = gate;
        push_d = 1'b1;
      end
      default: gate_d = GATE_NEUTRAL;
    endcase
  end

  // Registered outputs; reset drops gate and push immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate     <= GATE_NEUTRAL;
      push     <= 1'b0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      gate     <= gate_d;
      push     <= push_d;
      in_ready <= ready_d;
      busy     <= !ready_d;
      err      <= err_d;
    end
  end

  // First PUSH cycle: the timer still holds its freshly loaded value
  assign push_entry = (state_q == PUSH) && (timer_q == PUSH_LOAD);

  cargo_bin_counter #(.CNT_W(CNT_W)) u_light_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push_entry && (gate == GATE_LIGHT)),
    .clr   (clear_cnt),
    .cnt   (light_cnt)
  );

  cargo_bin_counter #(.CNT_W(CNT_W)) u_medium_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push_entry && (gate == GATE_MEDIUM)),
    .clr   (clear_cnt),
    .cnt   (medium_cnt)
  );

  cargo_bin_counter #(.CNT_W(CNT_W)) u_heavy_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push_entry && (gate == GATE_HEAVY)),
    .clr   (clear_cnt),
    .cnt   (heavy_cnt)
  );

endmodule

// File: tb/tb_cargo_diverter.sv
// Scoreboard bench for cargo_diverter with 2-bit counters so saturation is reachable.
// Latency: expectations queued at issue, popped by the monitor on push/err activity.
// Backpressure: stimulus waits on in_ready with a bounded cycle budget.
module tb_cargo_diverter;
  import cargo_pkg::*;

  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, light, medium_, heavy, clear_cnt;
  logic          in_ready, push, busy, err;
  logic [1:0]    gate;
  logic [CW-1:0] light_cnt, medium_cnt, heavy_cnt;

  cargo_diverter #(.SETTLE_CYCLES(2), .PUSH_CYCLES(8), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .light      (light),
    .medium_    (medium_),
    .heavy      (heavy),
    .clear_cnt  (clear_cnt),
    .gate       (gate),
    .push       (push),
    .busy       (busy),
    .err        (err),
    .light_cnt  (light_cnt),
    .medium_cnt (medium_cnt),
    .heavy_cnt  (heavy_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] gate;
    int         lc;
    int         mc;
    int         hc;
  } exp_t;

  exp_t exp_q[$];
  bit   err_q[$];
  int   m_l, m_m, m_h;
  int   lc_tab[5] = '{1, 2, 3, 3, 3};

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops an expectation on each push pulse and each err pulse
  exp_t cur;
  bit   mon_in_pulse = 1'b0;
  int   mon_len = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_in_pulse = 1'b0;
      mon_len      = 0;
    end else begin
      if (err) begin
        if (err_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_err actual=1 required=0 at %0t", $time);
        end else begin
          void'(err_q.pop_front());
        end
      end
      if (push && !mon_in_pulse) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_push actual=1 required=0 at %0t", $time);
          cur.gate = gate;
          cur.lc = int'(light_cnt);
          cur.mc = int'(medium_cnt);
          cur.hc = int'(heavy_cnt);
        end else begin
          cur = exp_q.pop_front();
          chk("push_gate", int'(gate), int'(cur.gate));
        end
        mon_in_pulse = 1'b1;
        mon_len      = 1;
      end else if (push) begin
        mon_len++;
        chk("push_gate_hold", int'(gate), int'(cur.gate));
      end else if (mon_in_pulse) begin
        mon_in_pulse = 1'b0;
        chk("push_len", mon_len, 8);
        chk("close_gate", int'(gate), int'(GATE_NEUTRAL));
        chk("sb_light_cnt", int'(light_cnt), cur.lc);
        chk("sb_medium_cnt", int'(medium_cnt), cur.mc);
        chk("sb_heavy_cnt", int'(heavy_cnt), cur.hc);
      end
    end
  end

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Update the reference counts and queue the expected push outcome
  task automatic model_item(input logic [2:0] cls, input bit clr);
    exp_t e;
    if (clr) begin
      m_l = 0;
      m_m = 0;
      m_h = 0;
    end else begin
      case (cls)
        3'b001:  m_l = sat(m_l + 1);
        3'b010:  m_m = sat(m_m + 1);
        default: m_h = sat(m_h + 1);
      endcase
    end
    case (cls)
      3'b001:  e.gate = GATE_LIGHT;
      3'b010:  e.gate = GATE_MEDIUM;
      default: e.gate = GATE_HEAVY;
    endcase
    e.lc = m_l;
    e.mc = m_m;
    e.hc = m_h;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_timeout", int'(in_ready), 1);
  endtask

  // One-cycle handshake; returns #1 into cycle 1 after the accepting edge
  task automatic handshake(input logic [2:0] cls);
    wait_ready();
    {heavy, medium_, light} = cls;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    {heavy, medium_, light} = 3'b000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_l = 0;
    m_m = 0;
    m_h = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    light = 1'b0;
    medium_ = 1'b0;
    heavy = 1'b0;
    clear_cnt = 1'b0;
    m_l = 0;
    m_m = 0;
    m_h = 0;
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_gate", int'(gate), 0);
    chk("rst_push", int'(push), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_light_cnt", int'(light_cnt), 0);
    chk("rst_medium_cnt", int'(medium_cnt), 0);
    chk("rst_heavy_cnt", int'(heavy_cnt), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single light item, cycle-by-cycle profile
    model_item(3'b001, 1'b0);
    handshake(3'b001);
    for (int k = 1; k <= 12; k++) begin
      chk($sformatf("t1_gate_c%0d", k), int'(gate), (k <= 10) ? 1 : 0);
      chk($sformatf("t1_push_c%0d", k), int'(push), (k >= 3 && k <= 10) ? 1 : 0);
      chk($sformatf("t1_ready_c%0d", k), int'(in_ready), (k == 12) ? 1 : 0);
      if (k < 12) begin
        @(posedge clk);
        #1;
      end
    end
    chk("t1_light_cnt", int'(light_cnt), 1);

    // Back-to-back with in_valid held: heavy, then medium
    begin
      int k;
      wait_ready();
      heavy = 1'b1;
      in_valid = 1'b1;
      model_item(3'b100, 1'b0);
      @(posedge clk);
      #1;
      heavy = 1'b0;
      medium_ = 1'b1;
      model_item(3'b010, 1'b0);
      k = 1;
      while (in_ready !== 1'b1 && k < 40) begin
        @(posedge clk);
        #1;
        k++;
      end
      chk("b2b_gap", k, 12);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      medium_ = 1'b0;
      wait_ready();
      chk("b2b_heavy_cnt", int'(heavy_cnt), 1);
      chk("b2b_medium_cnt", int'(medium_cnt), 1);
    end

    // Invalid classes: zero-hot and multi-hot
    for (int i = 0; i < 2; i++) begin
      logic [2:0] bad;
      bad = (i == 0) ? 3'b000 : 3'b011;
      err_q.push_back(1'b1);
      handshake(bad);
      chk($sformatf("bad%0d_err_hi", i), int'(err), 1);
      chk($sformatf("bad%0d_gate", i), int'(gate), 0);
      chk($sformatf("bad%0d_ready", i), int'(in_ready), 1);
      @(posedge clk);
      #1;
      chk($sformatf("bad%0d_err_lo", i), int'(err), 0);
      chk($sformatf("bad%0d_gate2", i), int'(gate), 0);
      chk($sformatf("bad%0d_lc", i), int'(light_cnt), m_l);
      chk($sformatf("bad%0d_mc", i), int'(medium_cnt), m_m);
      chk($sformatf("bad%0d_hc", i), int'(heavy_cnt), m_h);
    end

    // Saturation: five light items on a 2-bit counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      model_item(3'b001, 1'b0);
      handshake(3'b001);
      wait_ready();
      chk($sformatf("sat_light_%0d", i), int'(light_cnt), lc_tab[i]);
    end

    // Clear on the same edge as the PUSH-entry increment
    model_item(3'b010, 1'b0);
    handshake(3'b010);
    wait_ready();
    chk("clr_pre_medium", int'(medium_cnt), 1);
    model_item(3'b010, 1'b1);
    handshake(3'b010);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    clear_cnt = 1'b1;
    @(posedge clk);
    #1;
    clear_cnt = 1'b0;
    wait_ready();
    chk("clr_medium_cnt", int'(medium_cnt), 0);
    chk("clr_light_cnt", int'(light_cnt), 0);
    model_item(3'b010, 1'b0);
    handshake(3'b010);
    wait_ready();
    chk("clr_next_medium", int'(medium_cnt), 1);

    // Asynchronous reset in cycle 5 of a heavy item
    do_reset();
    model_item(3'b100, 1'b0);
    handshake(3'b100);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gate", int'(gate), 0);
    chk("arst_push", int'(push), 0);
    chk("arst_heavy_cnt", int'(heavy_cnt), 0);
    chk("arst_ready", int'(in_ready), 1);
    m_l = 0;
    m_m = 0;
    m_h = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", int'(in_ready), 1);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_heavy", int'(heavy_cnt), 0);
    model_item(3'b100, 1'b0);
    handshake(3'b100);
    wait_ready();
    chk("post_rst_heavy_item", int'(heavy_cnt), 1);

    repeat (5) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
